// File: rtl/audio_sigma_delta.sv
// Stereo first-order sigma-delta DAC front end with midscale soft-start ramp.
// Latency: a held sample reaches the 1-bit outputs one clk_sys after the clock that latches it.
// Backpressure: none; samples are accepted on every sample_ce strobe and the modulators run every clock.
//
// Ports:
//   clk_sys            single clock, all state on its rising edge
//   reset              synchronous, active-high
//   sample_ce          one-clock strobe qualifying l_in / r_in
//   signed_in          1 = two's complement samples, 0 = offset binary
//   vol                attenuation as a right shift of 0..3
//   mute               forces both modulators to midscale while running
//   l_in, r_in         BITS-wide samples
//   l_out, r_out       registered 1-bit modulator outputs
//   ready              high once the soft-start ramp has reached midscale

module audio_sigma_delta_mod #(
    parameter int BITS = 16
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [BITS-1:0] x,
    output logic            bit_out
);
    // The top accumulator bit is the carry of the most recent addition and
    // doubles as the registered output; the low bits carry the residue.
    logic [BITS:0] acc;
    logic [BITS:0] acc_next;

    always_comb begin
        acc_next = {1'b0, acc[BITS-1:0]} + {1'b0, x};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    assign bit_out = acc[BITS];
endmodule

module audio_sigma_delta #(
    parameter int BITS     = 16,
    parameter int RAMP_DIV = 4
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            sample_ce,
    input  logic            signed_in,
    input  logic [1:0]      vol,
    input  logic            mute,
    input  logic [BITS-1:0] l_in,
    input  logic [BITS-1:0] r_in,
    output logic            l_out,
    output logic            r_out,
    output logic            ready
);
    localparam logic [BITS-1:0] MID    = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0] MID_M1 = MID - 1'b1;

    // Divide counter is sized for the full legal RAMP_DIV range.
    localparam int              DIV_W    = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]       state;
    logic [BITS-1:0]  ramp;
    logic [DIV_W-1:0] div_cnt;
    logic [BITS-1:0]  l_hold;
    logic [BITS-1:0]  r_hold;
    logic [BITS-1:0]  l_att;
    logic [BITS-1:0]  r_att;
    logic [BITS-1:0]  l_x;
    logic [BITS-1:0]  r_x;

    // Two's complement to offset binary is just an MSB flip.
    function automatic logic [BITS-1:0] to_offset(input logic [BITS-1:0] s,
                                                  input logic            is_signed);
        logic [BITS-1:0] r;
        r = s;
        if (is_signed) begin
            r[BITS-1] = ~s[BITS-1];
        end
        return r;
    endfunction

    // Scale about midscale: the shifted value loses (MID >> v) of its offset,
    // which is added back so silence stays at MID. Cannot overflow BITS.
    function automatic logic [BITS-1:0] atten(input logic [BITS-1:0] h,
                                              input logic [1:0]      v);
        return (h >> v) + MID - (MID >> v);
    endfunction

    // ------------------------------------------------------------------
    // Soft-start sequencer: ramp climbs from 0 to MID, one step per
    // RAMP_DIV clocks, so the output does not jump at power-up.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= ST_RST;
            ramp    <= '0;
            div_cnt <= '0;
        end else begin
            case (state)
                ST_RST: begin
                    state <= ST_RAMP;
                end
                ST_RAMP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ramp    <= ramp + 1'b1;
                        if (ramp == MID_M1) begin
                            state <= ST_RUN;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RST;
                end
            endcase
        end
    end

    assign ready = (state == ST_RUN);

    // ------------------------------------------------------------------
    // Sample hold. Format conversion happens here so a later signed_in
    // change does not reinterpret an already held sample.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            l_hold <= MID;
            r_hold <= MID;
        end else if (sample_ce) begin
            l_hold <= to_offset(l_in, signed_in);
            r_hold <= to_offset(r_in, signed_in);
        end
    end

    // Volume and mute act on the hold registers combinationally, so they
    // take effect on the next modulator update without a new sample.
    always_comb begin
        l_att = atten(l_hold, vol);
        r_att = atten(r_hold, vol);
        l_x   = ramp;
        r_x   = ramp;
        if (state == ST_RUN) begin
            l_x = mute ? MID : l_att;
            r_x = mute ? MID : r_att;
        end
    end

    audio_sigma_delta_mod #(.BITS(BITS)) u_mod_l (
        .clk_sys (clk_sys),
        .reset   (reset),
        .x       (l_x),
        .bit_out (l_out)
    );

    audio_sigma_delta_mod #(.BITS(BITS)) u_mod_r (
        .clk_sys (clk_sys),
        .reset   (reset),
        .x       (r_x),
        .bit_out (r_out)
    );
endmodule

// File: tb/tb_audio_sigma_delta.sv
module tb_audio_sigma_delta;
    localparam int  BITS = 16;
    localparam int  M    = 32768;
    localparam longint FS = 65536;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        sample_ce;
    logic        signed_in;
    logic [1:0]  vol;
    logic        mute;
    logic [15:0] l_in;
    logic [15:0] r_in;
    logic        l_out;
    logic        r_out;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    audio_sigma_delta #(.BITS(BITS), .RAMP_DIV(1)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .sample_ce (sample_ce),
        .signed_in (signed_in),
        .vol       (vol),
        .mute      (mute),
        .l_in      (l_in),
        .r_in      (r_in),
        .l_out     (l_out),
        .r_out     (r_out),
        .ready     (ready)
    );

    task automatic check_val(input string tag, input longint obs,
                             input longint lo, input longint hi);
        n_tests++;
        if (obs < lo || obs > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic latch(input logic [15:0] l, input logic [15:0] r);
        l_in      = l;
        r_in      = r;
        sample_ce = 1'b1;
        step();
        sample_ce = 1'b0;
    endtask

    task automatic count_ones(input int n, output int lc, output int rc);
        lc = 0;
        rc = 0;
        repeat (n) begin
            step();
            lc += int'(l_out);
            rc += int'(r_out);
        end
    endtask

    // Reference: offset-binary level, attenuated about midscale by 2^v.
    function automatic int model_x(input logic [15:0] s, input bit sgn,
                                   input int v, input bit mu);
        int lvl;
        if (mu) return M;
        lvl = int'(s);
        if (sgn) lvl = (lvl + M) % 65536;
        return lvl / (1 << v) + M - M / (1 << v);
    endfunction

    // Over n updates with a constant level x, the number of carries is
    // floor((a0 + n*x) / 2^BITS) for some unknown residue a0 < 2^BITS.
    task automatic check_duty(input string tag, input int obs, input int n, input int x);
        longint tot;
        longint lo;
        tot = longint'(n) * longint'(x);
        lo  = tot / FS;
        check_val(tag, obs, lo, ((tot % FS) == 0) ? lo : lo + 1);
    endtask

    initial begin
        int lc;
        int rc;
        int n;
        int wcnt;
        int prev;
        int ramp_ones;
        longint ramp_sum;
        logic [15:0] sl;
        logic [15:0] sr;
        bit sg;
        bit mu;
        int v;

        reset     = 1'b1;
        sample_ce = 1'b0;
        signed_in = 1'b0;
        vol       = 2'd0;
        mute      = 1'b0;
        l_in      = '0;
        r_in      = '0;
        repeat (3) step();
        check_val("rst_l_out", l_out, 0, 0);
        check_val("rst_r_out", r_out, 0, 0);
        check_val("rst_ready", ready, 0, 0);
        // A strobe under reset must not disturb the midscale hold value.
        latch(16'hFFFF, 16'h0000);
        step();

        // Abort a ramp part way through.
        reset = 1'b0;
        step();                     // RAMP entry
        repeat (16'h1234) step();
        check_val("ramp_not_ready", ready, 0, 0);
        reset = 1'b1;
        step();
        check_val("midramp_rst_l", l_out, 0, 0);
        check_val("midramp_rst_r", r_out, 0, 0);
        check_val("midramp_rst_ready", ready, 0, 0);
        reset = 1'b0;
        step();                     // RAMP entry again, ramp back at 0

        n         = 0;
        wcnt      = 0;
        prev      = -1;
        ramp_ones = 0;
        while (!ready && n < 40000) begin
            step();
            n++;
            if (!ready) begin
                wcnt      += int'(l_out);
                ramp_ones += int'(l_out);
                if (n % 256 == 0) begin
                    if (prev >= 0) check_val("ramp_mono", wcnt, prev, 256);
                    prev = wcnt;
                    wcnt = 0;
                end
            end
        end
        check_val("ramp_len", n, 32768, 32768);
        // Updates 1..32767 see ramp levels 0..32766, starting from acc = 0.
        ramp_sum = 0;
        for (int i = 0; i < 32767; i++) ramp_sum += i;
        check_val("ramp_total", ramp_ones, ramp_sum / FS, ramp_sum / FS + 1);

        // Hold registers came out of reset at midscale.
        step();
        count_ones(64, lc, rc);
        check_val("run_mid_l", lc, 32, 32);
        check_val("run_mid_r", rc, 32, 32);

        // DC mapping, two's complement input.
        signed_in = 1'b1;
        vol       = 2'd0;
        latch(16'h0000, 16'h0000);
        step();
        count_ones(64, lc, rc);
        check_val("dc_zero_l", lc, 32, 32);
        check_val("dc_zero_r", rc, 32, 32);
        latch(16'h7FFF, 16'h8000);
        step();
        count_ones(4096, lc, rc);
        check_duty("dc_max_l", lc, 4096, model_x(16'h7FFF, 1'b1, 0, 1'b0));
        check_val("dc_min_r", rc, 0, 0);

        // Attenuation, offset binary.
        signed_in = 1'b0;
        vol       = 2'd2;
        latch(16'hFFFF, 16'h0000);
        step();
        count_ones(4096, lc, rc);
        check_duty("att_l", lc, 4096, model_x(16'hFFFF, 1'b0, 2, 1'b0));
        check_duty("att_r", rc, 4096, model_x(16'h0000, 1'b0, 2, 1'b0));

        // Mute and unmute without a new sample.
        vol = 2'd0;
        latch(16'h0000, 16'hFFFF);
        step();
        mute = 1'b1;
        count_ones(64, lc, rc);
        check_val("mute_r", rc, 32, 32);
        check_val("mute_l", lc, 32, 32);
        mute = 1'b0;
        count_ones(256, lc, rc);
        check_duty("unmute_r", rc, 256, model_x(16'hFFFF, 1'b0, 0, 1'b0));
        check_val("unmute_l", lc, 0, 0);

        // Sample strobe and volume change on the same clock.
        latch(16'hFFFF, 16'hFFFF);
        step();
        vol = 2'd3;
        latch(16'h0000, 16'h0000);
        count_ones(4096, lc, rc);
        check_duty("coinc_l", lc, 4096, model_x(16'h0000, 1'b0, 3, 1'b0));
        check_duty("coinc_r", rc, 4096, model_x(16'h0000, 1'b0, 3, 1'b0));

        // Randomised settings against the reference level model.
        for (int k = 0; k < 10; k++) begin
            sl = 16'($urandom);
            sr = 16'($urandom);
            sg = 1'($urandom_range(0, 1));
            v  = int'($urandom_range(0, 3));
            mu = ($urandom_range(0, 3) == 0);
            signed_in = sg;
            vol       = 2'(v);
            mute      = mu;
            latch(sl, sr);
            step();
            count_ones(1024, lc, rc);
            check_duty("rand_l", lc, 1024, model_x(sl, sg, v, mu));
            check_duty("rand_r", rc, 1024, model_x(sr, sg, v, mu));
        end
        mute = 1'b0;
        check_val("run_ready", ready, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_sigma_delta.md
AUDIO_SIGMA_DELTA -- requirements
Module: audio_sigma_delta

Interface
REQ-001 SHALL have parameter BITS, default 16: sample width per channel.
REQ-002 SHALL have parameter RAMP_DIV, default 4: clocks per ramp step (legal range 1..255).
REQ-003 SHALL have port clk_sys, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sample_ce, input, 1: one-clock strobe marking new samples on l_in/r_in.
REQ-006 SHALL have port signed_in, input, 1: quasi-static; 1 = l_in/r_in two's complement, 0 = offset binary.
REQ-007 SHALL have port vol, input, 2: attenuation, right shift of 0..3.
REQ-008 SHALL have port mute, input, 1: forces both channels to midscale.
REQ-009 SHALL have port l_in, input, BITS: left sample.
REQ-010 SHALL have port r_in, input, BITS: right sample.
REQ-011 SHALL have port l_out, output, 1: left 1-bit modulator output, registered.
REQ-012 SHALL have port r_out, output, 1: right 1-bit modulator output, registered.
REQ-013 SHALL have port ready, output, 1: high in RUN state.

Function
REQ-014 SHALL, on sample_ce=1, latch both channels into hold registers in the same clock; hold registers keep their value otherwise.
REQ-015 SHALL convert at latch time: signed_in=1 -> invert MSB; signed_in=0 -> pass unchanged.
REQ-016 SHALL compute the attenuated value u = (h >> vol) + M - (M >> vol), with M = 2^(BITS-1), in BITS bits; this never overflows, and vol=0 yields h.
REQ-017 SHALL apply vol and mute combinationally to the hold registers, so a change takes effect on the next modulator update without waiting for sample_ce.
REQ-018 SHALL implement an FSM with states RST, RAMP and RUN.
REQ-019 SHALL use RST only while reset is high; the first clock after reset deasserts SHALL enter RAMP.
REQ-020 SHALL, in RAMP, increment a BITS-bit ramp register from 0 by 1 every RAMP_DIV clocks via a divide counter.
REQ-021 SHALL enter RUN on the step at which ramp reaches M, with ready=1 from that same clock edge.
REQ-022 SHALL feed each modulator with ramp in RAMP state, with M if mute=1 in RUN state, and with u otherwise in RUN state.
REQ-023 SHALL implement each channel as a first-order modulator with accumulator acc of BITS+1 bits: every clock acc <= {0, acc[BITS-1:0]} + x, out <= acc[BITS] of the new value.
REQ-024 SHALL give a long-run fraction of ones equal to x / 2^BITS; x=0 gives constant 0, and x=M gives a 1,0 alternation after the first carry.
REQ-025 SHALL ignore sample_ce during RST; sample_ce SHALL latch normally during RAMP (hold is used once RUN is reached).
REQ-026 SHALL let a sample_ce coincident with a vol or mute change latch the new sample; that clock applies the new vol and mute to the old hold value.
REQ-027 SHALL, on reset mid-RUN or mid-RAMP, return to RST in one clock, abandoning the ramp; RAMP SHALL restart from 0 when reset is released.

Reset
REQ-028 SHALL, while reset=1, hold l_out=0, r_out=0, ready=0, acc=0, ramp=0, divide counter=0, and hold registers = M (midscale).
REQ-029 SHALL require no reset for any other state; none exists beyond the items in REQ-028.

Verification
REQ-030 SHALL cover ramp: BITS=16, RAMP_DIV=1, release reset -> ready rises exactly 32768 clocks after the RAMP entry clock; l_out duty during RAMP rises monotonically (per 256-clock window).
REQ-031 SHALL cover DC mapping: RUN, signed_in=1, vol=0, sample 0x0000 -> l_out alternates 1,0 (50%); sample 0x7FFF -> l_out=1 in 65535 of 65536 clocks; sample 0x8000 -> l_out constantly 0.
REQ-032 SHALL cover attenuation: signed_in=0, sample 0xFFFF, vol=2 -> u = 0x3FFF+0x8000-0x2000 = 0x9FFF; ones count over 65536 clocks = 40959 +/-1.
REQ-033 SHALL cover mute: RUN with r_in=0xFFFF (offset binary), assert mute -> r_out switches to 50% duty on the next clock; deassert mute -> r_out returns to ~100% without a new sample_ce.
REQ-034 SHALL cover reset mid-RAMP: assert reset at ramp=0x1234 for 1 clock -> outputs 0 and ready=0 next clock; the ramp restarts from 0.
REQ-035 SHALL cover a coincident event: sample_ce and a vol change from 0 to 3 in the same clock -> the hold register takes the new sample; the modulator input on the following clock reflects both changes.
